// File: rtl/im_pipe_fetch_if.sv
// Fetch-side bus of the instruction memory.
//   master : the CPU fetch stage (drives requests, consumes responses, raises flush)
//   slave  : the instruction memory (accepts requests, returns responses)
// Signals:
//   req_valid/req_ready/req_addr  - fetch request handshake, byte address
//   rsp_valid/rsp_ready           - response handshake
//   rsp_data/rsp_fault            - instruction word and misaligned/out-of-range flag
//   flush                         - drop everything in flight (branch redirect)
interface im_pipe_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        flush;

  modport master (
    output req_valid, req_addr, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/im_pipe_fetch.sv
// Instruction memory with a pipelined fetch port, an in-order response queue
// and an independent word-wide load port for boot/testbench initialisation.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset (memory contents survive it)
//   fetch      - im_pipe_fetch_if.slave: request/response handshake and flush
//   load_we    - load port write enable
//   load_addr  - byte offset into the array (not BASE-relative), bits [1:0] ignored
//   load_data  - write word, same byte order as fetched words
//   load_be    - byte enables, bit 3 selects load_data[31:24]
module im_pipe_fetch #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  im_pipe_fetch_if.slave        fetch,
  input  logic                  load_we,
  input  logic [31:0]           load_addr,
  input  logic [31:0]           load_data,
  input  logic [3:0]            load_be
);

  localparam int unsigned WORDS     = DEPTH_BYTES / 4;
  localparam int unsigned IW        = $clog2(WORDS);
  localparam int unsigned QDEPTH    = LATENCY + 1;
  localparam int unsigned PW        = $clog2(QDEPTH);
  localparam int unsigned CW        = $clog2(QDEPTH + 1);
  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

  // Byte slot k of a word holds the byte at address (word_base + k).
  // A load lane maps to the slot dictated by the byte order.
  function automatic logic [1:0] byte_slot(input int lane);
    return BIG_ENDIAN ? 2'(3 - lane) : 2'(lane);
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------- storage
  logic [7:0]    mem_q [WORDS][4];
  logic [IW-1:0] ld_idx;

  assign ld_idx = load_addr[IW+1:2];

  // NOTE: the memory array has no reset; clearing it would need a write port
  // per word and it must keep its image across a CPU reset anyway.
  always_ff @(posedge clk) begin
    if (load_we && (load_addr <= LAST_WORD)) begin
      for (int i = 0; i < 4; i++) begin
        if (load_be[i]) mem_q[ld_idx][byte_slot(i)] <= load_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- decode
  logic [31:0]   off;
  logic [IW-1:0] rd_idx;
  logic          rd_fault;
  logic [31:0]   rd_word;
  logic [31:0]   rd_data;

  assign off      = fetch.req_addr - BASE_ADDR;   // wraps modulo 2^32
  assign rd_idx   = off[IW+1:2];
  assign rd_fault = (off[1:0] != 2'b00) || (off > LAST_WORD);
  assign rd_word  = BIG_ENDIAN
                  ? {mem_q[rd_idx][0], mem_q[rd_idx][1], mem_q[rd_idx][2], mem_q[rd_idx][3]}
                  : {mem_q[rd_idx][3], mem_q[rd_idx][2], mem_q[rd_idx][1], mem_q[rd_idx][0]};
  // Faulting fetches return a NOP word.
  assign rd_data  = rd_fault ? 32'h0 : rd_word;

  // ---------------------------------------------------------------- handshake
  logic [CW-1:0] outs_q, outs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, pop;

  // Credit limit: never more accepted-but-unpopped requests than queue slots.
  assign fetch.req_ready = !rst && !fetch.flush && (outs_q < CW'(QDEPTH));
  assign accept          = fetch.req_valid && fetch.req_ready;
  assign pop             = fetch.rsp_valid && fetch.rsp_ready && !fetch.flush;

  // ---------------------------------------------------------------- delay line
  // The word is read on the accept edge; LATENCY-1 further stages delay it so
  // it lands in the queue at edge t+LATENCY-1.
  logic        push_valid;
  logic        push_fault;
  logic [31:0] push_data;

  if (LATENCY == 1) begin : g_direct
    assign push_valid = accept;
    assign push_fault = rd_fault;
    assign push_data  = rd_data;
  end else begin : g_pipe
    logic [LATENCY-2:0] stg_valid_q;
    logic [LATENCY-2:0] stg_fault_q;
    logic [31:0]        stg_data_q [LATENCY-1];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the order of statements
    // does not matter.
    always_ff @(posedge clk) begin
      if (rst || fetch.flush) begin
        stg_valid_q <= '0;
      end else begin
        stg_valid_q[0] <= accept;
        for (int i = 1; i < int'(LATENCY) - 1; i++) stg_valid_q[i] <= stg_valid_q[i-1];
      end
    end

    // Payload is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge clk) begin
      stg_data_q[0]  <= rd_data;
      stg_fault_q[0] <= rd_fault;
      for (int i = 1; i < int'(LATENCY) - 1; i++) begin
        stg_data_q[i]  <= stg_data_q[i-1];
        stg_fault_q[i] <= stg_fault_q[i-1];
      end
    end

    assign push_valid = stg_valid_q[LATENCY-2];
    assign push_fault = stg_fault_q[LATENCY-2];
    assign push_data  = stg_data_q[LATENCY-2];
  end

  // ---------------------------------------------------------------- response queue
  logic [31:0]       q_data_q [QDEPTH];
  logic [QDEPTH-1:0] q_fault_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       last_data_q;
  logic              last_fault_q;
  logic [31:0]       shown_data;
  logic              shown_fault;

  // An empty queue keeps presenting whatever was last on the outputs.
  assign shown_data  = (cnt_q != '0) ? q_data_q[rd_ptr_q]  : last_data_q;
  assign shown_fault = (cnt_q != '0) ? q_fault_q[rd_ptr_q] : last_fault_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    outs_d   = outs_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fetch.flush) begin
      outs_d   = '0;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      outs_d = outs_q + CW'(accept) - CW'(pop);
      cnt_d  = cnt_q + CW'(push_valid) - CW'(pop);
      if (push_valid) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)        rd_ptr_d = next_ptr(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q       <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_data_q  <= '0;
      last_fault_q <= 1'b0;
    end else begin
      outs_q       <= outs_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_data_q  <= shown_data;
      last_fault_q <= shown_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid) begin
      q_data_q[wr_ptr_q]  <= push_data;
      q_fault_q[wr_ptr_q] <= push_fault;
    end
  end

  assign fetch.rsp_valid = !rst && (cnt_q != '0);
  assign fetch.rsp_data  = rst ? 32'h0 : shown_data;
  assign fetch.rsp_fault = !rst && shown_fault;

endmodule
